// File: rtl/hba_master_port.sv
// ---------------------------------------------------------------------------
// hba_master_port
//
// Master-side bus access engine for an HBA master peripheral. The local core
// hands over one read or write command. The engine requests the bus from the
// arbiter and waits for the grant pulse. It then performs one transfer on the
// wired-OR HBA bus and returns a single-cycle response. That response carries
// either the read data or a timeout error.
//
// Ports
//   hba_clk       : bus clock; all state changes on its rising edge
//   hba_reset     : synchronous active-high reset
//   cmd_valid     : a command is presented by the local core
//   cmd_ready     : engine idle; the command is taken when valid & ready
//   cmd_rnw       : 1 = read, 0 = write
//   cmd_addr      : target address (peripheral id + register)
//   cmd_wdata     : write data
//   rsp_valid     : one-cycle response pulse
//   rsp_err       : 1 = transfer timed out (meaningful with rsp_valid)
//   rsp_rdata     : last read data, held until the next response
//   hba_mrequest  : bus request to the arbiter
//   hba_mgrant    : single-cycle grant pulse from the arbiter
//   hba_select    : this master owns the bus (ORed with other masters)
//   hba_rnw       : bus read/not-write
//   hba_abus      : bus address
//   hba_dbus      : bus write data
//   hba_dbus_in   : bus read data returned by the slaves
//   hba_xferDone  : slave reports the transfer is complete
// ---------------------------------------------------------------------------
module hba_master_port #(
  parameter int DBUS_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DBUS_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DBUS_WIDTH-1:0] rsp_rdata,
  output logic                  hba_mrequest,
  input  logic                  hba_mgrant,
  output logic                  hba_select,
  output logic                  hba_rnw,
  output logic [ADDR_WIDTH-1:0] hba_abus,
  output logic [DBUS_WIDTH-1:0] hba_dbus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus_in,
  input  logic                  hba_xferDone
);

  // The counter must be able to hold TIMEOUT-1. The terminal compare stops it
  // before it can wrap.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DBUS_WIDTH-1:0] DATA_ZERO = {DBUS_WIDTH{1'b0}};

  // Registered state
  logic [1:0]            state_r;
  logic                  cmd_rnw_r;
  logic [ADDR_WIDTH-1:0] cmd_addr_r;
  logic [DBUS_WIDTH-1:0] cmd_wdata_r;
  logic [CW-1:0]         count_r;
  logic                  mrequest_r;
  logic                  select_r;
  logic                  rnw_r;
  logic [ADDR_WIDTH-1:0] abus_r;
  logic [DBUS_WIDTH-1:0] dbus_r;
  logic                  rsp_valid_r;
  logic                  rsp_err_r;
  logic [DBUS_WIDTH-1:0] rsp_rdata_r;

  // Next-state values
  logic [1:0]            state_s;
  logic                  cmd_rnw_s;
  logic [ADDR_WIDTH-1:0] cmd_addr_s;
  logic [DBUS_WIDTH-1:0] cmd_wdata_s;
  logic [CW-1:0]         count_s;
  logic                  mrequest_s;
  logic                  select_s;
  logic                  rnw_s;
  logic [ADDR_WIDTH-1:0] abus_s;
  logic [DBUS_WIDTH-1:0] dbus_s;
  logic                  rsp_valid_s;
  logic                  rsp_err_s;
  logic [DBUS_WIDTH-1:0] rsp_rdata_s;

  // The engine takes a command only while idle. A new command can be taken
  // in the same cycle the previous response is shown.
  assign cmd_ready = (state_r == ST_IDLE);

  // Compute the next state and the next values of every registered output.
  always_comb begin
    state_s     = state_r;
    cmd_rnw_s   = cmd_rnw_r;
    cmd_addr_s  = cmd_addr_r;
    cmd_wdata_s = cmd_wdata_r;
    count_s     = count_r;
    mrequest_s  = mrequest_r;
    select_s    = select_r;
    rnw_s       = rnw_r;
    abus_s      = abus_r;
    dbus_s      = dbus_r;
    rsp_valid_s = 1'b0;              // the response is a pulse, never held
    rsp_err_s   = rsp_err_r;
    rsp_rdata_s = rsp_rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_rnw_s   = cmd_rnw;
          cmd_addr_s  = cmd_addr;
          cmd_wdata_s = cmd_wdata;
          mrequest_s  = 1'b1;
          state_s     = ST_REQ;
        end else begin
          state_s     = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Contention on the bus is unbounded, so there is no timeout here.
        if (hba_mgrant) begin
          mrequest_s = 1'b0;
          select_s   = 1'b1;
          rnw_s      = cmd_rnw_r;
          abus_s     = cmd_addr_r;
          // A read must not drive data onto the wired-OR bus.
          dbus_s     = cmd_rnw_r ? DATA_ZERO : cmd_wdata_r;
          count_s    = CNT_ZERO;
          state_s    = ST_XFER;
        end else begin
          mrequest_s = 1'b1;
        end
      end

      ST_XFER: begin
        // Completion is tested first so it wins over a timeout in the same cycle.
        if (hba_xferDone) begin
          select_s    = 1'b0;
          rnw_s       = 1'b0;
          abus_s      = ADDR_ZERO;
          dbus_s      = DATA_ZERO;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          if (cmd_rnw_r) begin
            rsp_rdata_s = hba_dbus_in;
          end else begin
            rsp_rdata_s = rsp_rdata_r;
          end
          state_s     = ST_IDLE;
        end else if (count_r == CNT_LAST) begin
          select_s    = 1'b0;
          rnw_s       = 1'b0;
          abus_s      = ADDR_ZERO;
          dbus_s      = DATA_ZERO;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          count_s     = count_r + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encoding: release the bus and go back to idle.
        state_s    = ST_IDLE;
        mrequest_s = 1'b0;
        select_s   = 1'b0;
        rnw_s      = 1'b0;
        abus_s     = ADDR_ZERO;
        dbus_s     = DATA_ZERO;
        count_s    = CNT_ZERO;
      end
    endcase
  end

  // State and output registers. Reset releases the bus and drops any pending command.
  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_r     <= ST_IDLE;
      cmd_rnw_r   <= 1'b0;
      cmd_addr_r  <= ADDR_ZERO;
      cmd_wdata_r <= DATA_ZERO;
      count_r     <= CNT_ZERO;
      mrequest_r  <= 1'b0;
      select_r    <= 1'b0;
      rnw_r       <= 1'b0;
      abus_r      <= ADDR_ZERO;
      dbus_r      <= DATA_ZERO;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= DATA_ZERO;
    end else begin
      state_r     <= state_s;
      cmd_rnw_r   <= cmd_rnw_s;
      cmd_addr_r  <= cmd_addr_s;
      cmd_wdata_r <= cmd_wdata_s;
      count_r     <= count_s;
      mrequest_r  <= mrequest_s;
      select_r    <= select_s;
      rnw_r       <= rnw_s;
      abus_r      <= abus_s;
      dbus_r      <= dbus_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_rdata_r <= rsp_rdata_s;
    end
  end

  assign hba_mrequest = mrequest_r;
  assign hba_select   = select_r;
  assign hba_rnw      = rnw_r;
  assign hba_abus     = abus_r;
  assign hba_dbus     = dbus_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_err      = rsp_err_r;
  assign rsp_rdata    = rsp_rdata_r;

endmodule
